sr_latch_seq: RTL and testbench

Pulse sequencer that shares one set/reset drive path among a bank of N SR NOR latches. It accepts one set or reset command at a time and drives a single latch's S or R input for a programmable number of cycles. A guard interval with all drives low follows each pulse, and the block reports whether the latch output reached the commanded value. It sits between control logic and the latch bank and guarantees the forbidden S=R=1 input combination never occurs on any latch.

---
 rtl/sr_latch_seq.sv | 134 +++++++++++++
 tb/tb_sr_latch_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_seq.sv
// sr_latch_seq: shares one set/reset drive path across a bank of N SR NOR latches.
// One command at a time: drive S or R of a single latch for PULSE_W cycles, then
// hold every drive low for GUARD_W cycles and report whether the latch followed.
// The drives only ever carry a one-hot copy of the latched target, so S=R=1 can
// never reach any latch.
module sr_latch_seq #(
    parameter int N       = 4,
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1,
    parameter int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [IW-1:0] cmd_idx,
    input  logic [N-1:0]  q_fb,
    output logic [N-1:0]  s_out,
    output logic [N-1:0]  r_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // One shared down-counter times both the pulse and the guard interval.
    localparam int CNT_MAX = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_W - 1);

    // Indices at or above N exist only when N is not a power of two.
    localparam logic [IW:0] IDX_LIMIT = (IW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_r;
    logic [N-1:0]  sel_r;
    logic [N-1:0]  cmd_sel;
    logic          idx_ok;
    logic          fb_bit;

    // Decode a latch index into a one-hot select; out-of-range indices give zero.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign cmd_sel   = onehot(cmd_idx);
    assign idx_ok    = ({1'b0, cmd_idx} < IDX_LIMIT);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Feedback of the commanded latch, picked with the stored one-hot select.
    assign fb_bit = |(q_fb & sel_r);

    // Capture the accepted command; only meaningful while a command is in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid && idx_ok) begin
            op_r  <= cmd_op;
            sel_r <= cmd_sel;
        end
    end

    // Sequencer FSM: accept, drive pulse, guard interval, completion report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            s_out <= '0;
            r_out <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (idx_ok) begin
                            state <= PULSE;
                            cnt   <= PULSE_LOAD;
                            s_out <= cmd_op ? cmd_sel : '0;
                            r_out <= cmd_op ? '0 : cmd_sel;
                        end else begin
                            // Bad index: nothing is driven, report failure at once.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state <= GUARD;
                        cnt   <= GUARD_LOAD;
                        s_out <= '0;
                        r_out <= '0;
                        done  <= 1'b1;
                        err   <= (fb_bit != op_r);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GUARD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    s_out <= '0;
                    r_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_seq.sv
// Bench for sr_latch_seq: a 4-latch instance wired to an SR latch model, plus a
// 3-latch instance for out-of-range indices.
module tb_sr_latch_seq;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       cmd_valid, cmd_op, cmd_ready;
    logic [1:0] cmd_idx;
    logic [3:0] q_fb, s_out, r_out;
    logic       busy, done, err;

    logic       b_valid, b_op, b_ready, b_busy, b_done, b_err;
    logic [1:0] b_idx;
    logic [2:0] b_q_fb, b_s_out, b_r_out;

    logic [3:0] latch_q = 4'b0000;
    logic [3:0] stuck_en, stuck_val;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state for the random phase (times in cycle numbers)
    int   cyc, m_ready_cyc, m_drv_first, m_drv_last, m_done_cyc, m_idx;
    logic m_op, m_err;
    int   acc_cnt, done_cnt;

    typedef struct {
        logic       op;
        logic [1:0] idx;
        logic [3:0] st_en;
        logic [3:0] st_val;
        logic [3:0] exp_s;
        logic [3:0] exp_r;
        logic       exp_err;
    } vec_t;

    vec_t vt[8];

    always #5 clk = ~clk;

    sr_latch_seq #(.N(4), .PULSE_W(P), .GUARD_W(G)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .q_fb(q_fb), .s_out(s_out),
        .r_out(r_out), .busy(busy), .done(done), .err(err)
    );

    sr_latch_seq #(.N(3), .PULSE_W(P), .GUARD_W(G)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_idx(b_idx), .q_fb(b_q_fb), .s_out(b_s_out),
        .r_out(b_r_out), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // SR NOR latch bank: S sets, R clears, neither holds
    always @(s_out, r_out) begin
        for (int i = 0; i < 4; i++) begin
            if (s_out[i]) latch_q[i] = 1'b1;
            else if (r_out[i]) latch_q[i] = 1'b0;
        end
    end

    assign q_fb = (latch_q & ~stuck_en) | (stuck_val & stuck_en);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_inv;
        chk("inv_s_and_r", 32'(s_out & r_out), 32'd0);
        chk("inv_onehot", 32'($countones(s_out | r_out) <= 1), 32'd1);
    endtask

    // Compare every DUT output to the time-based model for the current cycle
    task automatic model_check;
        logic [3:0] exp_s, exp_r;
        exp_s = '0;
        exp_r = '0;
        if (cyc >= m_drv_first && cyc <= m_drv_last) begin
            if (m_op) exp_s[m_idx] = 1'b1;
            else      exp_r[m_idx] = 1'b1;
        end
        chk("rnd_s_out", 32'(s_out), 32'(exp_s));
        chk("rnd_r_out", 32'(r_out), 32'(exp_r));
        chk("rnd_done", 32'(done), 32'(cyc == m_done_cyc));
        if (cyc == m_done_cyc) chk("rnd_err", 32'(err), 32'(m_err));
        chk("rnd_ready", 32'(cmd_ready), 32'(cyc >= m_ready_cyc));
        chk("rnd_busy", 32'(busy), 32'(cyc < m_ready_cyc));
        chk_inv();
        if (done) done_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        //         op    idx    st_en    st_val   exp_s    exp_r    err
        vt[0] = '{1'b1, 2'd2, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0};
        vt[1] = '{1'b0, 2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1};
        vt[2] = '{1'b0, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        vt[3] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};
        vt[4] = '{1'b1, 2'd3, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b1};
        vt[5] = '{1'b0, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        vt[6] = '{1'b1, 2'd1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0};
        vt[7] = '{1'b0, 2'd3, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_idx = 2'd0;
        stuck_en = 4'b0; stuck_val = 4'b0;
        b_valid = 1'b0; b_op = 1'b0; b_idx = 2'd0; b_q_fb = 3'b000;

        // Reset state, during and after reset
        repeat (2) tick();
        chk("rst_s_out", 32'(s_out), 0);
        chk("rst_r_out", 32'(r_out), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(done), 0);

        // Table-driven single commands
        for (int v = 0; v < 8; v++) begin
            stuck_en  = vt[v].st_en;
            stuck_val = vt[v].st_val;
            chk($sformatf("tbl%0d_ready_in", v), 32'(cmd_ready), 1);
            cmd_valid = 1'b1; cmd_op = vt[v].op; cmd_idx = vt[v].idx;
            tick();
            cmd_valid = 1'b0;
            for (int c = 0; c < P; c++) begin
                chk($sformatf("tbl%0d_s_pulse", v), 32'(s_out), 32'(vt[v].exp_s));
                chk($sformatf("tbl%0d_r_pulse", v), 32'(r_out), 32'(vt[v].exp_r));
                chk($sformatf("tbl%0d_busy", v), 32'(busy), 1);
                chk($sformatf("tbl%0d_ready_pulse", v), 32'(cmd_ready), 0);
                chk($sformatf("tbl%0d_done_early", v), 32'(done), 0);
                tick();
            end
            chk($sformatf("tbl%0d_s_guard", v), 32'(s_out), 0);
            chk($sformatf("tbl%0d_r_guard", v), 32'(r_out), 0);
            chk($sformatf("tbl%0d_done", v), 32'(done), 1);
            chk($sformatf("tbl%0d_err", v), 32'(err), 32'(vt[v].exp_err));
            chk($sformatf("tbl%0d_ready_guard", v), 32'(cmd_ready), 0);
            repeat (G) tick();
            chk($sformatf("tbl%0d_ready_out", v), 32'(cmd_ready), 1);
            chk($sformatf("tbl%0d_busy_out", v), 32'(busy), 0);
            chk($sformatf("tbl%0d_done_once", v), 32'(done), 0);
            if (v == 0) chk("tbl0_latch_q2", 32'(latch_q[2]), 1);
        end

        // Back-to-back with inputs changing during the pulse
        stuck_en = 4'b0;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_idx = 2'd0;
        tick();
        cmd_op = 1'b0; cmd_idx = 2'd3;
        for (int c = 0; c < P; c++) begin
            chk("b2b_s_hold", 32'(s_out), 32'h1);
            chk("b2b_r_hold", 32'(r_out), 0);
            chk("b2b_ready_low", 32'(cmd_ready), 0);
            tick();
        end
        chk("b2b_done1", 32'(done), 1);
        chk("b2b_err1", 32'(err), 0);
        chk("b2b_ready_guard", 32'(cmd_ready), 0);
        tick();
        chk("b2b_ready_k4", 32'(cmd_ready), 1);
        tick();
        chk("b2b_second_r", 32'(r_out), 32'h8);
        chk("b2b_second_s", 32'(s_out), 0);
        chk("b2b_second_busy", 32'(busy), 1);
        cmd_valid = 1'b0;
        tick();
        chk("b2b_second_r2", 32'(r_out), 32'h8);
        tick();
        chk("b2b_done2", 32'(done), 1);
        chk("b2b_err2", 32'(err), 0);
        tick();
        chk("b2b_ready_end", 32'(cmd_ready), 1);

        // Out-of-range index on the 3-latch instance
        chk("inv_ready_in", 32'(b_ready), 1);
        b_valid = 1'b1; b_op = 1'b1; b_idx = 2'd3;
        tick();
        chk("inv_done", 32'(b_done), 1);
        chk("inv_err", 32'(b_err), 1);
        chk("inv_s_out", 32'(b_s_out), 0);
        chk("inv_r_out", 32'(b_r_out), 0);
        chk("inv_ready", 32'(b_ready), 1);
        chk("inv_busy", 32'(b_busy), 0);
        tick();
        chk("inv_done_again", 32'(b_done), 1);
        chk("inv_err_again", 32'(b_err), 1);
        chk("inv_drive_again", 32'(b_s_out | b_r_out), 0);
        b_valid = 1'b0;
        tick();
        chk("inv_done_clear", 32'(b_done), 0);
        chk("inv_err_clear", 32'(b_err), 0);
        // Valid index on the 3-latch instance with feedback tied low
        b_valid = 1'b1; b_op = 1'b1; b_idx = 2'd2;
        tick();
        b_valid = 1'b0;
        chk("n3_s_out", 32'(b_s_out), 32'h4);
        tick();
        tick();
        chk("n3_done", 32'(b_done), 1);
        chk("n3_err_stuck0", 32'(b_err), 1);
        tick();
        chk("n3_ready", 32'(b_ready), 1);

        // Asynchronous reset in the middle of a pulse
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_idx = 2'd3;
        tick();
        cmd_valid = 1'b0;
        chk("mid_s_before", 32'(s_out), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_s_async", 32'(s_out), 0);
        chk("mid_r_async", 32'(r_out), 0);
        chk("mid_done_async", 32'(done), 0);
        chk("mid_err_async", 32'(err), 0);
        chk("mid_busy_async", 32'(busy), 0);
        chk("mid_ready_async", 32'(cmd_ready), 1);
        tick();
        chk("mid_ready_held", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_done", 32'(done), 0);
            chk("mid_idle", 32'(busy), 0);
        end
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_idx = 2'd1;
        tick();
        cmd_valid = 1'b0;
        chk("mid_new_s1", 32'(s_out), 32'h2);
        tick();
        chk("mid_new_s2", 32'(s_out), 32'h2);
        tick();
        chk("mid_new_done", 32'(done), 1);
        chk("mid_new_err", 32'(err), 0);
        tick();
        chk("mid_new_ready", 32'(cmd_ready), 1);

        // Random commands with random gaps against the time-based model
        cyc = 0; m_ready_cyc = 0; m_drv_first = 1; m_drv_last = 0; m_done_cyc = -1;
        m_idx = 0; m_op = 1'b0; m_err = 1'b0; acc_cnt = 0; done_cnt = 0;
        while (acc_cnt < 500 && cyc < 8000) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 1'($urandom);
            cmd_idx   = 2'($urandom_range(0, 3));
            acc = cmd_valid && (cyc >= m_ready_cyc);
            if (acc) begin
                stuck_en = 4'b0; stuck_val = 4'b0;
                if ($urandom_range(0, 3) == 0) begin
                    stuck_en[cmd_idx]  = 1'b1;
                    stuck_val[cmd_idx] = 1'($urandom);
                end
            end
            tick();
            cyc++;
            if (acc) begin
                m_op        = cmd_op;
                m_idx       = int'(cmd_idx);
                m_drv_first = cyc;
                m_drv_last  = cyc + P - 1;
                m_done_cyc  = cyc + P;
                m_ready_cyc = cyc + P + G;
                m_err       = ((stuck_en[m_idx] ? stuck_val[m_idx] : m_op) != m_op);
                acc_cnt++;
            end
            model_check();
        end
        cmd_valid = 1'b0;
        repeat (P + G + 1) begin
            tick();
            cyc++;
            model_check();
        end
        chk("rnd_accept_count", 32'(acc_cnt), 32'd500);
        chk("rnd_done_count", 32'(done_cnt), 32'(acc_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
